// File: rtl/bessel_filter_ctrl_if.sv
// Configuration request channel for bessel_filter_ctrl.
//
// Handshake: a request transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. The master holds cfg_coef stable while cfg_valid is 1
// and the transfer has not happened. cfg_ready never depends combinationally
// on cfg_valid. A transfer carrying cfg_coef == 0 is consumed but rejected:
// cfg_err pulses for one cycle and nothing else changes.
//
// Signals:
//   cfg_coef   master->slave  requested filter coefficient
//   cfg_valid  master->slave  request valid
//   cfg_ready  slave->master  request can be accepted this cycle
//   cfg_err    slave->master  1-cycle pulse after a rejected (zero) request
interface bessel_filter_ctrl_if #(
  parameter int COEF_WIDTH = 32
) ();
  logic [COEF_WIDTH-1:0] cfg_coef;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic                  cfg_err;

  modport master (output cfg_coef, output cfg_valid, input cfg_ready, input cfg_err);
  modport slave  (input cfg_coef, input cfg_valid, output cfg_ready, output cfg_err);
endinterface

// File: rtl/bessel_filter_ctrl.sv
// bessel_filter_ctrl
//   Sequencer/configurator for the first-order Bessel IIR filter on ADC A.
//   Owns the filter coefficient and the filter's active-low reset. Every
//   accepted nonzero coefficient update flushes the filter for FLUSH_CYCLES,
//   then masks the output for SETTLE_CYCLES before filtered data is passed on.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-low
//   cfg         configuration request channel (slave side)
//   filt_coef   coefficient driven to the filter
//   filt_rst_n  filter reset, active-low
//   adc_raw     unfiltered sample
//   adc_filt    filter output sample
//   adc_out     gated sample to the data splitter (1-cycle latency)
//   out_valid   adc_out holds settled filtered data
//   state       FSM state: 0=FLUSH 1=SETTLE 2=RUN
//   reconf_cnt  count of accepted nonzero updates (wraps)
//
// Build option:
//   RAW_PASSTHRU_EN  when defined, adc_out follows adc_raw during FLUSH and
//                    SETTLE (out_valid stays 0); otherwise adc_out is 0 there.
module bessel_filter_ctrl #(
  parameter int ADC_WIDTH     = 14,
  parameter int COEF_WIDTH    = 32,
  parameter int DEFAULT_COEF  = 2158,
  parameter int FLUSH_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  bessel_filter_ctrl_if.slave         cfg,
  output logic [COEF_WIDTH-1:0]       filt_coef,
  output logic                        filt_rst_n,
  input  logic signed [ADC_WIDTH-1:0] adc_raw,
  input  logic signed [ADC_WIDTH-1:0] adc_filt,
  output logic signed [ADC_WIDTH-1:0] adc_out,
  output logic                        out_valid,
  output logic [1:0]                  state,
  output logic [15:0]                 reconf_cnt
);

  localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_FLUSH   = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RUN     = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_ready_q, cfg_err_q;
  logic             hs, accept, reject, ready_state;

  assign state         = state_q;
  assign cfg.cfg_ready = cfg_ready_q;
  assign cfg.cfg_err   = cfg_err_q;

  // Next-state logic. A handshake only counts in SETTLE/RUN so a corrupted
  // ready flag in the illegal state cannot load a coefficient.
  always_comb begin
    ready_state = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    hs          = cfg.cfg_valid && cfg_ready_q && ready_state;
    accept      = hs && (cfg.cfg_coef != '0);
    reject      = hs && (cfg.cfg_coef == '0);
    state_d     = state_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (accept) begin
          // Restart from scratch: a partial settle is never credited.
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  // State register plus registered outputs. Outputs are derived from the
  // next state so filt_rst_n, out_valid and adc_out change on the same edge
  // as the state transition that causes them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= '0;
      filt_coef   <= COEF_WIDTH'(DEFAULT_COEF);
      filt_rst_n  <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      adc_out     <= '0;
      out_valid   <= 1'b0;
      reconf_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      filt_rst_n <= (state_d != ST_FLUSH);
      // Ready follows the current state one edge late; cleared immediately
      // on the accepting edge so a held valid cannot be taken twice.
      cfg_ready_q <= ready_state && !accept;
      cfg_err_q   <= reject;
      if (accept) begin
        // The filter is being held in reset from this edge on, so the new
        // coefficient is never seen mid-filter.
        filt_coef  <= cfg.cfg_coef;
        reconf_cnt <= reconf_cnt + 16'd1;
      end
      out_valid <= (state_d == ST_RUN);
      if (state_d == ST_RUN) begin
        adc_out <= adc_filt;
      end else begin
`ifdef RAW_PASSTHRU_EN
        adc_out <= adc_raw;
`else
        adc_out <= '0;
`endif
      end
    end
  end

  // adc_raw only feeds the passthrough build; keep it referenced otherwise.
  logic unused_raw;
  assign unused_raw = ^adc_raw;

endmodule

// File: tb/tb_bessel_filter_ctrl.sv
// Self-checking bench for bessel_filter_ctrl with FLUSH_CYCLES=4,
// SETTLE_CYCLES=16. Outputs are sampled 1 ns after each rising edge and
// inputs are changed at the same point.
module tb_bessel_filter_ctrl;

  localparam int AW = 14;
  localparam int CW = 32;

  logic                 clk;
  logic                 reset;
  logic [CW-1:0]        filt_coef;
  logic                 filt_rst_n;
  logic signed [AW-1:0] adc_raw;
  logic signed [AW-1:0] adc_filt;
  logic signed [AW-1:0] adc_out;
  logic                 out_valid;
  logic [1:0]           state;
  logic [15:0]          reconf_cnt;

  int n_vec;
  int n_err;

  bessel_filter_ctrl_if #(.COEF_WIDTH(CW)) cfg_if ();

  bessel_filter_ctrl #(
    .ADC_WIDTH(AW), .COEF_WIDTH(CW), .DEFAULT_COEF(2158),
    .FLUSH_CYCLES(4), .SETTLE_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cfg(cfg_if),
    .filt_coef(filt_coef), .filt_rst_n(filt_rst_n),
    .adc_raw(adc_raw), .adc_filt(adc_filt), .adc_out(adc_out),
    .out_valid(out_valid), .state(state), .reconf_cnt(reconf_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]        coef;
    logic                 valid;
    logic signed [AW-1:0] raw;
    logic signed [AW-1:0] filt;
    logic [1:0]           e_state;
    logic [CW-1:0]        e_coef;
    logic                 e_rst_n;
    logic                 e_ready;
    logic                 e_err;
    logic                 e_ov;
    logic signed [AW-1:0] e_adc;
    logic [15:0]          e_reconf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [CW-1:0] coef);
    cfg_if.cfg_valid = valid;
    cfg_if.cfg_coef  = coef;
  endtask

  function automatic logic [31:0] ext(input logic signed [AW-1:0] v);
    return {18'd0, v};
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, ".state"},      {30'd0, state}, 32'd0);
    chk({tag, ".filt_coef"},  filt_coef, 32'd2158);
    chk({tag, ".filt_rst_n"}, {31'd0, filt_rst_n}, 32'd0);
    chk({tag, ".cfg_ready"},  {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk({tag, ".cfg_err"},    {31'd0, cfg_if.cfg_err}, 32'd0);
    chk({tag, ".adc_out"},    ext(adc_out), 32'd0);
    chk({tag, ".out_valid"},  {31'd0, out_valid}, 32'd0);
    chk({tag, ".reconf_cnt"}, {16'd0, reconf_cnt}, 32'd0);
  endtask

  initial begin
    logic signed [AW-1:0] exp_adc;
    logic [1:0]           exp_st;
    n_vec = 0;
    n_err = 0;

    // Run-mode vectors, applied starting in RUN with reconf_cnt == 0.
    //            coef   vld  raw      filt     st    e_coef rst rdy err ov  e_adc    recnf
    vecs[0] = '{32'd0,    1'b0, 14'sd700, 14'sd200, 2'd2, 32'd2158, 1'b1, 1'b1, 1'b0, 1'b1, 14'sd200, 16'd0};
    vecs[1] = '{32'd0,    1'b1, 14'sd701, 14'sd201, 2'd2, 32'd2158, 1'b1, 1'b1, 1'b1, 1'b1, 14'sd201, 16'd0};
    vecs[2] = '{32'd0,    1'b0, 14'sd702, -14'sd5,  2'd2, 32'd2158, 1'b1, 1'b1, 1'b0, 1'b1, -14'sd5,  16'd0};
    vecs[3] = '{32'd4000, 1'b1, 14'sd703, 14'sd300, 2'd0, 32'd4000, 1'b0, 1'b0, 1'b0, 1'b0, 14'sd0,   16'd1};
    vecs[4] = '{32'd0,    1'b0, 14'sd704, 14'sd301, 2'd0, 32'd4000, 1'b0, 1'b0, 1'b0, 1'b0, 14'sd0,   16'd1};

    // Reset held for a few edges.
    reset = 1'b0;
    drive(1'b0, '0);
    adc_raw  = '0;
    adc_filt = '0;
    repeat (3) step();
    chk_reset_values("rst");

    // Release: cycle k reflects the outputs after k edges with reset high.
    reset = 1'b1;
    for (int k = 0; k < 22; k++) begin
      adc_raw  = AW'(500 + k);
      adc_filt = AW'(100 + k);
      exp_st = (k < 4) ? 2'd0 : ((k < 20) ? 2'd1 : 2'd2);
      if (k == 0) exp_adc = '0;
      else if (k >= 20) exp_adc = AW'(100 + k - 1);
`ifdef RAW_PASSTHRU_EN
      else exp_adc = AW'(500 + k - 1);
`else
      else exp_adc = '0;
`endif
      chk("boot.filt_rst_n", {31'd0, filt_rst_n}, {31'd0, (k >= 4)});
      chk("boot.out_valid",  {31'd0, out_valid},  {31'd0, (k >= 20)});
      chk("boot.state",      {30'd0, state},      {30'd0, exp_st});
      chk("boot.cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, (k >= 5)});
      chk("boot.filt_coef",  filt_coef, 32'd2158);
      chk("boot.adc_out",    ext(adc_out), ext(exp_adc));
      step();
    end

    // Table-driven run-mode vectors.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].valid, vecs[i].coef);
      adc_raw  = vecs[i].raw;
      adc_filt = vecs[i].filt;
      step();
      exp_adc = vecs[i].e_adc;
`ifdef RAW_PASSTHRU_EN
      if (!vecs[i].e_ov) exp_adc = vecs[i].raw;
`endif
      chk("vec.state",      {30'd0, state},      {30'd0, vecs[i].e_state});
      chk("vec.filt_coef",  filt_coef,           vecs[i].e_coef);
      chk("vec.filt_rst_n", {31'd0, filt_rst_n}, {31'd0, vecs[i].e_rst_n});
      chk("vec.cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, vecs[i].e_ready});
      chk("vec.cfg_err",    {31'd0, cfg_if.cfg_err},   {31'd0, vecs[i].e_err});
      chk("vec.out_valid",  {31'd0, out_valid},  {31'd0, vecs[i].e_ov});
      chk("vec.adc_out",    ext(adc_out),        ext(exp_adc));
      chk("vec.reconf_cnt", {16'd0, reconf_cnt}, {16'd0, vecs[i].e_reconf});
    end

    // out_valid returns exactly 20 edges after the accepting edge
    // (vecs[3] was edge 0, vecs[4] edge 1).
    drive(1'b0, '0);
    adc_filt = 14'sd42;
    for (int j = 2; j <= 20; j++) begin
      step();
      chk("relock.out_valid",  {31'd0, out_valid},  {31'd0, (j == 20)});
      chk("relock.filt_rst_n", {31'd0, filt_rst_n}, {31'd0, (j >= 4)});
      chk("relock.filt_coef",  filt_coef, 32'd4000);
    end
    chk("relock.state",      {30'd0, state}, 32'd2);
    chk("relock.reconf_cnt", {16'd0, reconf_cnt}, 32'd1);

    // New update (edge 0), then cfg_valid held with 3000 from mid-FLUSH.
    drive(1'b1, 32'h1234);
    step();
    chk("hold.first_accept", {16'd0, reconf_cnt}, 32'd2);
    drive(1'b0, '0);
    step();
    drive(1'b1, 32'd3000);
    for (int e = 2; e <= 6; e++) begin
      step();
      exp_st = (e < 4 || e == 6) ? 2'd0 : 2'd1;
      chk("hold.reconf_cnt", {16'd0, reconf_cnt}, (e == 6) ? 32'd3 : 32'd2);
      chk("hold.cfg_ready",  {31'd0, cfg_if.cfg_ready}, {31'd0, (e == 5)});
      chk("hold.filt_coef",  filt_coef, (e == 6) ? 32'd3000 : 32'h1234);
      chk("hold.state",      {30'd0, state}, {30'd0, exp_st});
    end
    // Accepted in SETTLE: a full flush restarts from that edge.
    drive(1'b0, '0);
    for (int e = 7; e <= 12; e++) begin
      step();
      chk("reflush.filt_rst_n", {31'd0, filt_rst_n}, {31'd0, (e >= 10)});
      chk("reflush.reconf_cnt", {16'd0, reconf_cnt}, 32'd3);
      chk("reflush.filt_coef",  filt_coef, 32'd3000);
    end
    chk("reflush.state", {30'd0, state}, 32'd1);

    // Reset during SETTLE with a request pending: request is dropped.
    reset = 1'b0;
    drive(1'b1, 32'd7000);
    step();
    chk_reset_values("midrst");
    reset = 1'b1;
    drive(1'b0, '0);
    repeat (2) step();
    chk("postrst.filt_coef", filt_coef, 32'd2158);
    chk("postrst.state",     {30'd0, state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
